// File: rtl/sample_packer.sv
// sample_packer: packs samples from one selected source LSB-first into OUT_WIDTH-bit words
module sample_packer #(
  parameter int IN_WIDTH = 12,
  parameter int OUT_WIDTH = 8,
  parameter int N_SRC = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      io_enable,
  input  logic [(N_SRC > 1 ? $clog2(N_SRC) : 1)-1:0] io_mode,
  input  logic [N_SRC-1:0]                          io_in_valid,
  input  logic [N_SRC*IN_WIDTH-1:0]                 io_in_bits,
  input  logic                                      io_out_ready,
  output logic                                      io_out_valid,
  output logic [OUT_WIDTH-1:0]                      io_out_bits,
  output logic                                      io_busy,
  output logic [CNT_WIDTH-1:0]                      io_overflow
);
  localparam int SEL_W = N_SRC > 1 ? $clog2(N_SRC) : 1;
  localparam int ACC_W = IN_WIDTH + OUT_WIDTH;
  localparam int FW = $clog2(ACC_W + 1);
  localparam logic [FW-1:0] OW = FW'(OUT_WIDTH);
  localparam logic [FW-1:0] IW = FW'(IN_WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state;
  logic [ACC_W-1:0] acc, acc_e, placed;
  logic [FW-1:0] fill, fill_e;
  logic [SEL_W-1:0] sel;
  logic [IN_WIDTH-1:0] sample;
  logic emit, strobe, fits;
  assign io_out_valid = fill >= OW;
  assign io_out_bits = acc[OUT_WIDTH-1:0];
  assign io_busy = state != IDLE;
  // post-emit view of the accumulator and the selected source; out-of-range sel shifts in zeros
  always_comb begin
    emit = io_out_valid & io_out_ready;
    acc_e = emit ? acc >> OUT_WIDTH : acc;
    fill_e = emit ? fill - OW : fill;
    strobe = 1'(io_in_valid >> sel);
    sample = IN_WIDTH'(io_in_bits >> (32'(sel) * IN_WIDTH));
    placed = ACC_W'(sample) << fill_e;
    fits = 32'(fill_e) + IN_WIDTH <= ACC_W;
  end
  // control FSM plus accumulator, fill and overflow bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      fill <= '0;
      sel <= '0;
      io_overflow <= '0;
    end else begin
      acc <= acc_e;
      fill <= fill_e;
      case (state)
        IDLE: if (io_enable) begin
          state <= RUN;
          sel <= io_mode;
          io_overflow <= '0;
        end
        RUN: if (!io_enable) state <= FLUSH;
          else if (strobe && fits) begin
            acc <= acc_e | placed;
            fill <= fill_e + IW;
          end else if (strobe && ~&io_overflow) io_overflow <= io_overflow + CNT_WIDTH'(1);
        FLUSH: if (fill_e == '0) state <= IDLE;
          else if (fill_e < OW) fill <= OW;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: directed vectors checked against a bit-queue model every cycle
module tb_sample_packer;
  logic clock = 0, reset = 1, io_enable = 0, io_out_ready = 0;
  logic [0:0] io_mode = '0;
  logic [1:0] io_in_valid = '0;
  logic [23:0] io_in_bits = '0;
  logic out_valid, busy, out_valid4, busy4;
  logic [7:0] out_bits, out_bits4;
  logic [15:0] ovf;
  logic [3:0] ovf4;
  int n_vec = 0, n_err = 0;
  bit chk_on = 0;
  always #5 clock = ~clock;
  sample_packer dut (
    .clock(clock), .reset(reset), .io_enable(io_enable), .io_mode(io_mode),
    .io_in_valid(io_in_valid), .io_in_bits(io_in_bits), .io_out_ready(io_out_ready),
    .io_out_valid(out_valid), .io_out_bits(out_bits), .io_busy(busy), .io_overflow(ovf)
  );
  sample_packer #(.CNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .io_enable(io_enable), .io_mode(io_mode),
    .io_in_valid(io_in_valid), .io_in_bits(io_in_bits), .io_out_ready(io_out_ready),
    .io_out_valid(out_valid4), .io_out_bits(out_bits4), .io_busy(busy4), .io_overflow(ovf4)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: pending bits as a queue, state as 0=idle 1=run 2=flush
  bit mq[$];
  int m_state = 0, m_sel = 0, m_ovf = 0, m_ovf4 = 0;
  logic act_v;
  logic [7:0] act_b;
  logic [7:0] dut_words[$];
  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      m_state = 0; m_sel = 0; m_ovf = 0; m_ovf4 = 0;
    end else begin
      if (act_v === 1'b1 && io_out_ready) dut_words.push_back(act_b);
      if (mq.size() >= 8 && io_out_ready) for (int i = 0; i < 8; i++) void'(mq.pop_front());
      if (m_state == 0) begin
        if (io_enable) begin m_state = 1; m_sel = int'(io_mode); m_ovf = 0; m_ovf4 = 0; end
      end else if (m_state == 1) begin
        if (!io_enable) m_state = 2;
        else if (io_in_valid[m_sel]) begin
          if (mq.size() + 12 <= 20) for (int i = 0; i < 12; i++) mq.push_back(io_in_bits[m_sel*12+i]);
          else begin
            if (m_ovf < 65535) m_ovf++;
            if (m_ovf4 < 15) m_ovf4++;
          end
        end
      end else begin
        if (mq.size() == 0) m_state = 0;
        else while (mq.size() < 8) mq.push_back(1'b0);
      end
    end
  end
  // per-cycle comparison of both instances against the model
  always @(negedge clock) begin
    logic [7:0] mb;
    act_v = out_valid;
    act_b = out_bits;
    if (chk_on) begin
      chk("valid", out_valid, mq.size() >= 8);
      chk("busy", busy, m_state != 0);
      chk("overflow", ovf, m_ovf);
      chk("valid4", out_valid4, mq.size() >= 8);
      chk("busy4", busy4, m_state != 0);
      chk("overflow4", ovf4, m_ovf4);
      if (mq.size() >= 8) begin
        for (int i = 0; i < 8; i++) mb[i] = mq[i];
        chk("bits", out_bits, mb);
        chk("bits4", out_bits4, mb);
      end
    end
  end
  task automatic cyc(input logic en, input logic md, input logic [1:0] v,
                     input logic [11:0] s0, input logic [11:0] s1, input logic rdy);
    io_enable = en; io_mode = md; io_in_valid = v; io_in_bits = {s1, s0}; io_out_ready = rdy;
    @(negedge clock);
  endtask
  task automatic idle(input logic en, input int n);
    for (int i = 0; i < n; i++) cyc(en, 0, 2'b00, 12'h0, 12'h0, 1);
  endtask
  task automatic chk_words(input string name, input int n, input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
    chk({name, "_count"}, dut_words.size(), n);
    if (n > 0 && dut_words.size() > 0) chk({name, "_w0"}, dut_words[0], w0);
    if (n > 1 && dut_words.size() > 1) chk({name, "_w1"}, dut_words[1], w1);
    if (n > 2 && dut_words.size() > 2) chk({name, "_w2"}, dut_words[2], w2);
    dut_words.delete();
  endtask
  initial begin
    @(negedge clock);
    cyc(1, 1, 2'b11, 12'hFFF, 12'hFFF, 1);
    chk_on = 1;
    chk("rst_valid", out_valid, 0);
    chk("rst_bits", out_bits, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    reset = 0;
    dut_words.delete();
    // two samples stream out as three words
    cyc(1, 0, 2'b00, 12'h0, 12'h0, 1);
    cyc(1, 0, 2'b01, 12'hABC, 12'h0, 1);
    cyc(1, 0, 2'b01, 12'h123, 12'h0, 1);
    idle(1, 3);
    idle(0, 3);
    chk_words("two_samples", 3, 8'hBC, 8'h3A, 8'h12);
    chk("two_samples_ovf", ovf, 0);
    // single sample flushed with zero padding
    cyc(1, 0, 2'b00, 12'h0, 12'h0, 1);
    cyc(1, 0, 2'b01, 12'hABC, 12'h0, 1);
    cyc(0, 0, 2'b00, 12'h0, 12'h0, 1);
    cyc(0, 0, 2'b00, 12'h0, 12'h0, 1);
    chk("flush_pad_valid", out_valid, 1);
    chk("flush_pad_busy", busy, 1);
    cyc(0, 0, 2'b00, 12'h0, 12'h0, 1);
    chk("flush_done_busy", busy, 0);
    chk_words("flush", 2, 8'hBC, 8'h0A, 8'h00);
    // back-pressure drops two samples, residue held until flush
    cyc(1, 0, 2'b00, 12'h0, 12'h0, 0);
    cyc(1, 0, 2'b01, 12'hABC, 12'h0, 0);
    cyc(1, 0, 2'b01, 12'h111, 12'h0, 0);
    cyc(1, 0, 2'b01, 12'h222, 12'h0, 0);
    chk("drop_ovf", ovf, 2);
    idle(1, 2);
    chk("residue_valid", out_valid, 0);
    chk("residue_busy", busy, 1);
    idle(0, 4);
    chk_words("residue", 2, 8'hBC, 8'h0A, 8'h00);
    // mode 1 latched; source-0 strobes and later mode changes are ignored
    cyc(1, 1, 2'b00, 12'h0, 12'h0, 1);
    cyc(1, 1, 2'b01, 12'hABC, 12'h0, 1);
    cyc(1, 0, 2'b01, 12'hABC, 12'h0, 1);
    cyc(1, 0, 2'b01, 12'h123, 12'h0, 1);
    idle(0, 3);
    chk_words("unselected", 0, 8'h00, 8'h00, 8'h00);
    chk("unselected_ovf", ovf, 0);
    // mode 1 picks source 1 even when both strobe
    cyc(1, 1, 2'b00, 12'h0, 12'h0, 1);
    cyc(1, 0, 2'b11, 12'hABC, 12'h5A5, 1);
    idle(0, 4);
    chk_words("src1", 2, 8'hA5, 8'h05, 8'h00);
    // overflow saturation, then cleared on the next start
    cyc(1, 0, 2'b00, 12'h0, 12'h0, 0);
    for (int i = 0; i < 21; i++) cyc(1, 0, 2'b01, 12'hABC, 12'h0, 0);
    chk("sat_ovf16", ovf, 20);
    chk("sat_ovf4", ovf4, 15);
    idle(0, 4);
    chk_words("sat", 2, 8'hBC, 8'h0A, 8'h00);
    cyc(1, 0, 2'b00, 12'h0, 12'h0, 1);
    chk("clear_ovf4", ovf4, 0);
    chk("clear_ovf16", ovf, 0);
    idle(0, 2);
    // reset mid-run discards partial data
    cyc(1, 0, 2'b00, 12'h0, 12'h0, 1);
    cyc(1, 0, 2'b01, 12'hABC, 12'h0, 1);
    cyc(1, 0, 2'b00, 12'h0, 12'h0, 1);
    cyc(1, 0, 2'b01, 12'h123, 12'h0, 1);
    reset = 1;
    cyc(0, 0, 2'b00, 12'h0, 12'h0, 1);
    reset = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_bits", out_bits, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", ovf, 0);
    idle(0, 4);
    chk_words("mid_rst", 1, 8'hBC, 8'h00, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
